prach_hb5_pair: RTL
===================

Name: prach_hb5_pair

Overview:
- Polyphase pair builder directly upstream of the HB5 half-band decimator in the PRACH long-format chain.
- Takes one time-multiplexed complex-component sample stream (one 16-bit sample per slot, channel tagged) and groups every two consecutive samples of the same channel into an even/odd pair.
- Emits each pair on dp1/dp2 with one valid per pair, halving the per-channel rate. This is the format the HB5 polyphase input consumes.
- Per-channel phase and pending-sample state are held across the 256-slot TDM frame.

Parameters:
- NUM_CHANNEL, 256, TDM slots per frame; sizes the state arrays, channel index width 8.
- NUM_CHANNEL_USED, 48, channels with chn < NUM_CHANNEL_USED are processed; others never produce output valid.
- LATENCY, 2, fixed din-to-dout latency in clk cycles; not user-tunable, exposed for benches.

Ports:
- clk  in  1  processing clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din_dq  in  16  input sample, signed two's complement.
- din_dv  in  1  input sample valid.
- din_chn  in  8  channel index of din_dq.
- sync_in  in  1  frame sync pulse, one cycle.
- dout_dp1  out  16  even (first-arrived) sample of the pair.
- dout_dp2  out  16  odd (second-arrived) sample of the pair.
- dout_dv  out  1  pair valid.
- dout_chn  out  8  channel index, delayed din_chn.
- sync_out  out  1  sync_in delayed by LATENCY.
- err  out  1  sticky pairing-error flag; see Optional Feature.

Behaviour:
Interface and reset:
- One clock. Reset is synchronous and active-high: rst sampled high at a clk edge resets the block.
- Reset values: dout_dp1=0, dout_dp2=0, dout_dv=0, dout_chn=0, sync_out=0, err=0.
- Reset clears all per-channel phase bits and the delay pipeline. The pending-sample store is not reset.
- rst asserted mid-operation discards any half-built pair. The first valid sample per channel after rst deassertion is treated as even.

Per-channel state:
- phase[NUM_CHANNEL] bits.
- pend[NUM_CHANNEL] 16-bit pending-sample store, RAM-inferable, one write and one read per cycle.

Stage 1, cycle T, din_dv=1 and din_chn < NUM_CHANNEL_USED:
- phase[chn]=0: write pend[chn] <= din_dq; set phase[chn] <= 1; the pair is not complete.
- phase[chn]=1: read pend[chn]; set phase[chn] <= 0; mark the pair complete.
- din_dv=0 or chn >= NUM_CHANNEL_USED: no state change; the pair is not complete.

Stage 2, cycle T+2 (outputs registered, LATENCY=2):
- dout_dv = complete.
- dout_dp1 = pend value.
- dout_dp2 = din_dq from cycle T.
- dout_chn = din_chn from cycle T, for every cycle regardless of valid.
- dout_dp1/dout_dp2 hold their previous values when dout_dv=0.

Read-during-write:
- The same channel on back-to-back cycles must return the just-written sample; a forwarding path is mandatory.

sync_in:
- Clears every phase bit in the same cycle.
- If din_dv=1 on the same cycle as sync_in, sync takes effect first: that sample is taken as even (written to pend, phase set to 1).
- sync_out = sync_in delayed exactly LATENCY cycles, alongside dout_chn.

Arithmetic:
- None. Samples pass bit-exact with no width change.

Optional Feature:
- Macro: PRACH_HB5_PAIR_ERR_EN.
- Defined: err sets (sticky until rst) when sync_in arrives while any used channel has phase=1, i.e. an orphaned even sample is dropped. It also sets when din_dv=1 with din_chn >= NUM_CHANNEL_USED. err updates one cycle after the offending input.
- Undefined: err tied to 0, no detection logic.

Test Plan:
- rst high 2 cycles, then chn 3 samples 0x0010 then 0x0020 in slots 256 cycles apart -> single dout_dv, dp1=0x0010, dp2=0x0020, chn=3, 2 cycles after second input; no valid after the first.
- Full 48-channel frames, chn c value 0x100*k+c on frame k, two frames -> 48 pairs in slot order, dp1 from frame 0, dp2 from frame 1, values bit-exact including 0x8000 and 0x7FFF.
- chn 5 on back-to-back cycles with 0x1111, 0x2222 -> dp1=0x1111, dp2=0x2222 (forwarding check).
- chn 7 even sample 0xAAAA, then sync_in, then 0xBBBB, 0xCCCC -> no pair with 0xAAAA; pair dp1=0xBBBB, dp2=0xCCCC. sync_out pulses 2 cycles after sync_in. err=1 with macro defined, 0 without.
- sync_in and din_dv on the same cycle (chn 2, 0x0001), then 0x0002 -> pair (0x0001, 0x0002).
- din_chn=60 valid samples -> dout_dv stays 0, dout_chn=60 delayed 2 cycles. err=1 only with PRACH_HB5_PAIR_ERR_EN defined. rst mid-pair clears state and err to 0.

Source files
------------

// File: rtl/prach_hb5_pair.sv
// Polyphase pair builder ahead of the PRACH HB5 half-band decimator: groups two consecutive
// samples per TDM channel into an even/odd pair. Optional error flag: PRACH_HB5_PAIR_ERR_EN.
module prach_hb5_pair #(
  parameter int NUM_CHANNEL      = 256,
  parameter int NUM_CHANNEL_USED = 48,
  parameter int LATENCY          = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din_dq,
  input  logic        din_dv,
  input  logic [7:0]  din_chn,
  input  logic        sync_in,
  output logic [15:0] dout_dp1,
  output logic [15:0] dout_dp2,
  output logic        dout_dv,
  output logic [7:0]  dout_chn,
  output logic        sync_out,
  output logic        err
);

  localparam logic [7:0] USED = 8'(NUM_CHANNEL_USED);

  logic [NUM_CHANNEL-1:0] phase_q, phase_d;
  logic [15:0]            pend_q [NUM_CHANNEL];

  // Registered write port: the write lands in pend_q one cycle late.
  logic        wr_en_q;
  logic [7:0]  wr_chn_q;
  logic [15:0] wr_dq_q;

  logic        in_used;
  logic        is_odd;
  logic [15:0] rd_data;

  logic        s1_dv_q;
  logic [15:0] s1_dp1_q, s1_dp2_q;

  logic        dout_dv_q;
  logic [15:0] dout_dp1_q, dout_dp2_q;
  logic [7:0]  chn_pipe_q [LATENCY];
  logic [LATENCY-1:0] sync_pipe_q;

  // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    in_used = din_dv && (din_chn < USED);
    // sync clears phases before this cycle's sample is classified
    is_odd  = !sync_in && phase_q[din_chn];
    phase_d = sync_in ? '0 : phase_q;
    if (in_used) phase_d[din_chn] = !is_odd;
    rd_data = (wr_en_q && (wr_chn_q == din_chn)) ? wr_dq_q : pend_q[din_chn];
  end

  // NOTE: the pending-sample RAM is deliberately not reset; phase bits alone mark validity.
  always_ff @(posedge clk) begin
    if (wr_en_q) pend_q[wr_chn_q] <= wr_dq_q;
    wr_chn_q <= din_chn;
    wr_dq_q  <= din_dq;
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      wr_en_q     <= 1'b0;
      s1_dv_q     <= 1'b0;
      s1_dp1_q    <= '0;
      s1_dp2_q    <= '0;
      dout_dv_q   <= 1'b0;
      dout_dp1_q  <= '0;
      dout_dp2_q  <= '0;
      sync_pipe_q <= '0;
      for (int i = 0; i < LATENCY; i++) chn_pipe_q[i] <= '0;
    end else begin
      phase_q  <= phase_d;
      wr_en_q  <= in_used && !is_odd;
      s1_dv_q  <= in_used && is_odd;
      s1_dp1_q <= rd_data;
      s1_dp2_q <= din_dq;
      dout_dv_q <= s1_dv_q;
      if (s1_dv_q) begin
        dout_dp1_q <= s1_dp1_q;
        dout_dp2_q <= s1_dp2_q;
      end
      sync_pipe_q   <= {sync_pipe_q[LATENCY-2:0], sync_in};
      chn_pipe_q[0] <= din_chn;
      for (int i = 1; i < LATENCY; i++) chn_pipe_q[i] <= chn_pipe_q[i-1];
    end
  end

  assign dout_dv  = dout_dv_q;
  assign dout_dp1 = dout_dp1_q;
  assign dout_dp2 = dout_dp2_q;
  assign dout_chn = chn_pipe_q[LATENCY-1];
  assign sync_out = sync_pipe_q[LATENCY-1];

`ifdef PRACH_HB5_PAIR_ERR_EN
  logic err_q;

  // Orphaned even sample dropped by sync, or a valid sample on an unused channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((sync_in && (|phase_q[NUM_CHANNEL_USED-1:0])) ||
                 (din_dv && (din_chn >= USED))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
